// File: rtl/dice_pkg.sv
// -----------------------------------------------------------------------------
// dice_pkg
// Shared definitions for the electronic dice: the roller FSM state encoding,
// the face width and the face constants. The downstream LED encoder imports
// the same face constants so both stages agree on what 0 and 1..6 mean.
// -----------------------------------------------------------------------------
package dice_pkg;

   localparam int DICE_W = 3;

   localparam logic [DICE_W-1:0] DICE_BLANK = 3'd0;
   localparam logic [DICE_W-1:0] DICE_MIN   = 3'd1;
   localparam logic [DICE_W-1:0] DICE_MAX   = 3'd6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROLL   = 2'd1,
      SETTLE = 2'd2,
      SHOW   = 2'd3
   } dice_state_t;

   // Face sequence 1->2->...->6->1. A blank face (or the unused code 7, which
   // should never occur) restarts the sequence at 1, so 7 is never produced.
   function automatic logic [DICE_W-1:0] next_face(input logic [DICE_W-1:0] face);
      logic [DICE_W-1:0] result;
      if ((face == DICE_BLANK) || (face >= DICE_MAX)) begin
         result = DICE_MIN;
      end else begin
         result = face + DICE_W'(1);
      end
      return result;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Conditions a raw asynchronous push-button: a two-flop synchronizer followed
// by a stability counter. The output flips only after the synchronized level
// has disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
//
// Ports:
//   clk  in  1  system clock
//   rst  in  1  asynchronous active-high reset
//   in   in  1  raw button level, asynchronous to clk
//   out  out 1  debounced level, registered
// -----------------------------------------------------------------------------
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic out
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync_meta;
   logic             sync_q;
   logic [CNT_W-1:0] stable_cnt;
   logic             db_q;

   // Two-flop synchronizer: sync_meta may go metastable, sync_q is the first
   // flop whose value the rest of the design is allowed to look at.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         sync_meta <= in;
         sync_q    <= sync_meta;
      end
   end

   // Count consecutive cycles in which the synchronized level disagrees with
   // the debounced level. The flip happens on the edge where the count would
   // reach DEBOUNCE_CYCLES, i.e. on the DEBOUNCE_CYCLES-th disagreeing sample.
   // Any agreeing sample throws the partial count away, so a bounce restarts
   // the whole wait.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_cnt <= '0;
         db_q       <= 1'b0;
      end else if (sync_q != db_q) begin
         if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_cnt <= '0;
            db_q       <= sync_q;
         end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
         end
      end else begin
         stable_cnt <= '0;
      end
   end

   assign out = db_q;

endmodule

// File: rtl/dice_roller.sv
// -----------------------------------------------------------------------------
// dice_roller
// Front end of the electronic dice. While the debounced button is held the
// face spins one step per clock; after release it decelerates through
// SETTLE_STEPS more advances spaced BASE_INTERVAL, 2*BASE_INTERVAL, ... cycles
// apart, then holds the final face and pulses Done.
//
// Ports:
//   clk        in  1  system clock
//   rst        in  1  asynchronous active-high reset
//   Button     in  1  raw push-button, asynchronous, active-high
//   DiceValue  out 3  current face: 0 = blank, 1..6 = face
//   Rolling    out 1  high while spinning or settling
//   Done       out 1  one-cycle pulse on the first cycle the final face shows
// -----------------------------------------------------------------------------
module dice_roller
   import dice_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SETTLE_STEPS    = 4,
   parameter int BASE_INTERVAL   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Button,
   output logic [DICE_W-1:0] DiceValue,
   output logic              Rolling,
   output logic              Done
);

   localparam int INT_W  = $clog2(BASE_INTERVAL * (2 ** (SETTLE_STEPS - 1))) + 1;
   localparam int STEP_W = $clog2(SETTLE_STEPS + 1);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SETTLE_STEPS - 1);

   logic              btn_db;
   dice_state_t       state, state_next;
   logic [DICE_W-1:0] face, face_next;
   logic [INT_W-1:0]  interval_cnt, interval_next;
   logic [STEP_W-1:0] step_cnt, step_next;
   logic              done_q, done_next;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk (clk),
      .rst (rst),
      .in  (Button),
      .out (btn_db)
   );

   // State, face, settle counters and the Done pulse are all plain registers
   // so DiceValue and Done never see a combinational path from the button.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         face         <= DICE_BLANK;
         interval_cnt <= '0;
         step_cnt     <= '0;
         done_q       <= 1'b0;
      end else begin
         state        <= state_next;
         face         <= face_next;
         interval_cnt <= interval_next;
         step_cnt     <= step_next;
         done_q       <= done_next;
      end
   end

   // Next-state and datapath logic.
   // ROLL advances the face on every edge spent in ROLL, including the edge
   // that leaves it, so N cycles in ROLL give exactly N advances; the edge
   // that enters ROLL does not advance.
   // SETTLE loads BASE_INTERVAL on entry and expires when the counter is at 1,
   // which makes the first advance land exactly BASE_INTERVAL edges after
   // entry. Each later reload is BASE_INTERVAL << (steps done), i.e. double
   // the previous interval. The last step skips the reload because the next
   // doubling would not fit the counter and is never needed.
   // A fresh press in SETTLE wins over a pending expiry and drops progress.
   always_comb begin
      state_next    = state;
      face_next     = face;
      interval_next = interval_cnt;
      step_next     = step_cnt;
      done_next     = 1'b0;

      case (state)
         IDLE, SHOW: begin
            if (btn_db) begin
               state_next = ROLL;
            end
         end

         ROLL: begin
            face_next = next_face(face);
            if (!btn_db) begin
               state_next    = SETTLE;
               interval_next = INT_W'(BASE_INTERVAL);
               step_next     = '0;
            end
         end

         SETTLE: begin
            if (btn_db) begin
               state_next = ROLL;
            end else if (interval_cnt == INT_W'(1)) begin
               face_next = next_face(face);
               step_next = step_cnt + STEP_W'(1);
               if (step_cnt == LAST_STEP) begin
                  state_next    = SHOW;
                  interval_next = '0;
               end else begin
                  interval_next = INT_W'(BASE_INTERVAL) << (step_cnt + STEP_W'(1));
               end
            end else begin
               interval_next = interval_cnt - INT_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      done_next = (state_next == SHOW) && (state != SHOW);
   end

   assign DiceValue = face;
   assign Rolling   = (state == ROLL) || (state == SETTLE);
   assign Done      = done_q;

endmodule

// File: tb/tb_dice_roller.sv
// -----------------------------------------------------------------------------
// tb_dice_roller
// Directed self-checking bench for dice_roller at default parameters.
// Time references inside each scenario count clock edges after the moment the
// button was last changed; all sampling happens 1 time unit after a posedge.
// -----------------------------------------------------------------------------
module tb_dice_roller;

   logic       clk = 1'b0;
   logic       rst;
   logic       Button;
   logic [2:0] DiceValue;
   logic       Rolling;
   logic       Done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dice_roller dut (
      .clk       (clk),
      .rst       (rst),
      .Button    (Button),
      .DiceValue (DiceValue),
      .Rolling   (Rolling),
      .Done      (Done)
   );

   // Advance n clock edges and land just after the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      Button = 1'b0;
      rst    = 1'b1;
      tick(2);
      rst    = 1'b0;
   endtask

   // Outputs are zero straight out of reset and stay that way with no press.
   task automatic test_reset();
      do_reset();
      checks++;
      if (DiceValue !== 3'd0) begin errors++; $display("[TB] FAIL reset_dice: got %0d expected 0", DiceValue); end
      checks++;
      if (Rolling !== 1'b0) begin errors++; $display("[TB] FAIL reset_rolling: got %0b expected 0", Rolling); end
      checks++;
      if (Done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", Done); end
      for (int i = 0; i < 40; i++) begin
         tick(1);
         checks++;
         if ({DiceValue, Rolling, Done} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL idle_quiet: cycle %0d got dice=%0d rolling=%0b done=%0b expected all 0", i, DiceValue, Rolling, Done);
         end
      end
   endtask

   // A 10-cycle pulse is shorter than the debounce window and must be ignored.
   task automatic test_glitch();
      Button = 1'b1;
      tick(10);
      Button = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         checks++;
         if (Rolling !== 1'b0 || DiceValue !== 3'd0) begin
            errors++;
            $display("[TB] FAIL glitch: cycle %0d got rolling=%0b dice=%0d expected 0/0", i, Rolling, DiceValue);
         end
      end
   endtask

   // Wait (bounded) for the Done pulse while timing the face changes.
   // Returns the gaps between successive changes, measured from the call.
   task automatic wait_settle(output int gaps[4], output int nchg, output bit seen);
      logic [2:0] prev_val;
      int         last_i;
      prev_val = DiceValue;
      last_i   = 0;
      nchg     = 0;
      seen     = 1'b0;
      for (int k = 0; k < 4; k++) gaps[k] = 0;
      for (int i = 1; i <= 200 && !seen; i++) begin
         tick(1);
         if (DiceValue !== prev_val) begin
            if (nchg < 4) gaps[nchg] = i - last_i;
            nchg++;
            last_i   = i;
            prev_val = DiceValue;
         end
         if (Done === 1'b1) seen = 1'b1;
      end
   endtask

   // Full press of 40 cycles from IDLE, then release and settle.
   task automatic test_press_release();
      int         gaps[4];
      int         nchg;
      bit         seen;
      int         exp_gap[4];
      logic [2:0] exp_face;
      exp_gap = '{8, 16, 32, 64};

      Button = 1'b1;
      tick(18);
      checks++;
      if (Rolling !== 1'b0) begin errors++; $display("[TB] FAIL roll_early: got %0b expected 0", Rolling); end
      tick(1);
      checks++;
      if (Rolling !== 1'b1) begin errors++; $display("[TB] FAIL roll_rise: got %0b expected 1", Rolling); end
      checks++;
      if (DiceValue !== 3'd0) begin errors++; $display("[TB] FAIL roll_entry_face: got %0d expected 0", DiceValue); end
      for (int i = 1; i <= 7; i++) begin
         tick(1);
         exp_face = 3'(((i - 1) % 6) + 1);
         checks++;
         if (DiceValue !== exp_face) begin
            errors++;
            $display("[TB] FAIL roll_seq: advance %0d got %0d expected %0d", i, DiceValue, exp_face);
         end
      end
      tick(14);
      Button = 1'b0;
      tick(19);
      checks++;
      if (DiceValue !== 3'd4 || Rolling !== 1'b1) begin
         errors++;
         $display("[TB] FAIL settle_entry: got dice=%0d rolling=%0b expected 4/1", DiceValue, Rolling);
      end

      wait_settle(gaps, nchg, seen);
      checks++;
      if (seen !== 1'b1) begin errors++; $display("[TB] FAIL settle_done_timeout: got seen=%0b expected 1", seen); end
      checks++;
      if (nchg != 4) begin errors++; $display("[TB] FAIL settle_steps: got %0d expected 4", nchg); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (gaps[k] != exp_gap[k]) begin
            errors++;
            $display("[TB] FAIL settle_gap%0d: got %0d expected %0d", k, gaps[k], exp_gap[k]);
         end
      end
      checks++;
      if (DiceValue !== 3'd2 || Rolling !== 1'b0) begin
         errors++;
         $display("[TB] FAIL show_face: got dice=%0d rolling=%0b expected 2/0", DiceValue, Rolling);
      end
      for (int i = 0; i < 10; i++) begin
         tick(1);
         checks++;
         if (Done !== 1'b0 || DiceValue !== 3'd2 || Rolling !== 1'b0) begin
            errors++;
            $display("[TB] FAIL show_hold: cycle %0d got done=%0b dice=%0d rolling=%0b expected 0/2/0", i, Done, DiceValue, Rolling);
         end
      end
   endtask

   // Re-press from SHOW (face 2): no Done, resume from held face, then a
   // 36-cycle press lands the settle on 6; a further press must wrap 6 -> 1.
   task automatic test_show_repress();
      int gaps[4];
      int nchg;
      bit seen;

      Button = 1'b1;
      for (int i = 1; i <= 18; i++) begin
         tick(1);
         checks++;
         if (Done !== 1'b0 || Rolling !== 1'b0) begin
            errors++;
            $display("[TB] FAIL show_repress_wait: cycle %0d got done=%0b rolling=%0b expected 0/0", i, Done, Rolling);
         end
      end
      tick(1);
      checks++;
      if (Rolling !== 1'b1 || DiceValue !== 3'd2 || Done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL show_repress_roll: got rolling=%0b dice=%0d done=%0b expected 1/2/0", Rolling, DiceValue, Done);
      end
      tick(1);
      checks++;
      if (DiceValue !== 3'd3) begin errors++; $display("[TB] FAIL show_resume: got %0d expected 3", DiceValue); end
      tick(16);
      Button = 1'b0;
      tick(19);
      checks++;
      if (DiceValue !== 3'd2) begin errors++; $display("[TB] FAIL show_settle_entry: got %0d expected 2", DiceValue); end
      wait_settle(gaps, nchg, seen);
      checks++;
      if (seen !== 1'b1 || DiceValue !== 3'd6 || Rolling !== 1'b0) begin
         errors++;
         $display("[TB] FAIL show_six: got seen=%0b dice=%0d rolling=%0b expected 1/6/0", seen, DiceValue, Rolling);
      end

      tick(3);
      Button = 1'b1;
      tick(19);
      checks++;
      if (Rolling !== 1'b1 || DiceValue !== 3'd6) begin
         errors++;
         $display("[TB] FAIL wrap_entry: got rolling=%0b dice=%0d expected 1/6", Rolling, DiceValue);
      end
      tick(1);
      checks++;
      if (DiceValue !== 3'd1) begin errors++; $display("[TB] FAIL wrap_six_to_one: got %0d expected 1", DiceValue); end
      Button = 1'b0;
   endtask

   // Press again after two settle steps, check restart at the 8-cycle
   // interval, then pull reset asynchronously in the middle of SETTLE.
   task automatic test_settle_repress();
      do_reset();
      Button = 1'b1;
      tick(40);
      Button = 1'b0;
      tick(19);
      checks++;
      if (DiceValue !== 3'd4) begin errors++; $display("[TB] FAIL sr_entry: got %0d expected 4", DiceValue); end
      tick(8);
      checks++;
      if (DiceValue !== 3'd5) begin errors++; $display("[TB] FAIL sr_step0: got %0d expected 5", DiceValue); end
      tick(16);
      checks++;
      if (DiceValue !== 3'd6) begin errors++; $display("[TB] FAIL sr_step1: got %0d expected 6", DiceValue); end
      tick(1);
      Button = 1'b1;
      tick(19);
      checks++;
      if (Rolling !== 1'b1 || DiceValue !== 3'd6) begin
         errors++;
         $display("[TB] FAIL sr_reroll: got rolling=%0b dice=%0d expected 1/6", Rolling, DiceValue);
      end
      tick(1);
      checks++;
      if (DiceValue !== 3'd1) begin errors++; $display("[TB] FAIL sr_adv1: got %0d expected 1", DiceValue); end
      tick(1);
      checks++;
      if (DiceValue !== 3'd2) begin errors++; $display("[TB] FAIL sr_adv2: got %0d expected 2", DiceValue); end
      tick(5);
      Button = 1'b0;
      tick(19);
      checks++;
      if (DiceValue !== 3'd2) begin errors++; $display("[TB] FAIL sr_resettle_entry: got %0d expected 2", DiceValue); end
      tick(7);
      checks++;
      if (DiceValue !== 3'd2) begin errors++; $display("[TB] FAIL sr_restart_early: got %0d expected 2", DiceValue); end
      tick(1);
      checks++;
      if (DiceValue !== 3'd3) begin errors++; $display("[TB] FAIL sr_restart_8: got %0d expected 3", DiceValue); end

      tick(3);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({DiceValue, Rolling, Done} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: got dice=%0d rolling=%0b done=%0b expected all 0", DiceValue, Rolling, Done);
      end
      tick(1);
      rst = 1'b0;
   endtask

   // Random button timing; invariants checked every cycle.
   task automatic test_random();
      logic prev_done;
      int   hold;
      do_reset();
      prev_done = 1'b0;
      for (int seg = 0; seg < 60; seg++) begin
         Button = 1'($urandom_range(0, 1));
         hold   = $urandom_range(1, 80);
         for (int j = 0; j < hold; j++) begin
            tick(1);
            checks++;
            if (DiceValue === 3'd7) begin errors++; $display("[TB] FAIL rand_seven: got %0d expected 0..6", DiceValue); end
            checks++;
            if (Done === 1'b1 && prev_done === 1'b1) begin errors++; $display("[TB] FAIL rand_done_twice: got done=1 twice expected single pulse"); end
            checks++;
            if (Done === 1'b1 && Rolling !== 1'b0) begin errors++; $display("[TB] FAIL rand_done_rolling: got rolling=%0b expected 0 with done", Rolling); end
            prev_done = Done;
         end
      end
      Button = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      Button = 1'b0;
      test_reset();
      test_glitch();
      test_press_release();
      test_show_repress();
      test_settle_repress();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
